stall_fifo: RTL
===============

Name: stall_fifo

Overview:
- Downstream consumer end of the pipeline valid/stall interface.
- Accepts data from an upstream pipeline hold stage and buffers it in a DEPTH-entry FIFO.
- Drives the stall back upstream when it cannot accept more data.
- Re-presents buffered data to the next stage using the same valid/stall convention. Sits between pipeline stages where a consumer can stall for multiple cycles.

Parameters:
- WIDTH, 1: data width in bits.
- DEPTH, 4: number of FIFO entries. Must be a power of two, >= 2.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  upstream data.
- input_valid  input  1  upstream data valid, already gated by stall upstream.
- stall_out  output  1  stall driven back to the upstream stage.
- data_out  output  WIDTH  data presented to the downstream stage.
- stall_in  input  1  stall from the downstream stage.
- valid_out  output  1  data_out valid this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous and active-low (reset_n).
  - While reset_n is 0: rd_ptr, wr_ptr and count are 0; stall_out=0; valid_out=0; data_out=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries immediately. The first accept is possible on the first posedge after deassertion.
- Push:
  - push = input_valid && !stall_out.
  - On push: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping modulo DEPTH.
  - input_valid while stall_out=1 is ignored. Nothing is written, and no error flag is raised.
- Pop:
  - valid_out = reset_n && !stall_in && (count != 0), matching the upstream convention that valid is suppressed while stalled.
  - pop = valid_out. On pop, rd_ptr increments, wrapping modulo DEPTH.
  - data_out = mem[rd_ptr] whenever count != 0. It is held stable while stall_in=1.
  - When empty, data_out holds its last value; it is don't-care to the consumer.
- Latency:
  - Minimum 1 cycle: data pushed on edge N is available as valid_out in cycle N+1.
  - No combinational bypass from data_in to data_out.
- count:
  - count <= count + push - pop.
  - Simultaneous push and pop leave count unchanged while both pointers advance.
- stall_out:
  - stall_out = (count == DEPTH). It depends on registered state only.
  - There is no combinational path from stall_in or input_valid to stall_out.
  - When full, a pop in cycle N clears stall_out in cycle N+1. Push while full in the same cycle as a pop is not permitted.
- Boundaries:
  - Full + pop: count goes to DEPTH-1 and stall deasserts the next cycle.
  - Empty + push with stall_in=0: valid_out rises the next cycle.
  - Empty + push + stall_in=1: entry retained, valid_out=0 until stall_in drops.
  - Pointer wrap at DEPTH-1 -> 0 is seamless.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No pop when count=0.

Decomposition:
- Shared pipeline package: clog2-derived pointer width helper; valid/stall handshake doc constants.
- No typedefs are needed beyond WIDTH vectors.
- One natural sub-module: stall_fifo_mem, a DEPTH x WIDTH register array with write-enable/address and asynchronous read port. Control logic (pointers, count, stall, valid) stays in stall_fifo.

Test Plan (WIDTH=8, DEPTH=4):
- Reset release, push 0x11 with stall_in=0 -> valid_out=1 with data_out=0x11 exactly one cycle later; count returns to 0 after that cycle.
- stall_in=1, push 0xA0,0xA1,0xA2,0xA3 -> count=4, stall_out=1 the cycle after the 4th push. A 5th input_valid with 0xFF is ignored. Release stall_in -> outputs A0,A1,A2,A3 on consecutive cycles, then valid_out=0.
- Full FIFO, stall_in pulses low for one cycle -> one pop of 0xA0, count=3, stall_out=0 next cycle. The next push is accepted and lands at the wrapped wr_ptr.
- Continuous push of 0..15 with stall_in=0 -> count stays at 1. Outputs 0..15 in order with 1-cycle latency; pointers wrap 4 times.
- Full FIFO, assert reset_n=0 asynchronously mid-cycle -> stall_out, valid_out and count go to 0 without waiting for a clock edge. After release, the old data is never presented.
- Random input_valid/stall_in (50% each) for 2000 cycles -> output sequence equals the accepted input sequence (scoreboard); count is never >4; stall_out is never asserted while count<4.

Source files
------------

// File: rtl/stall_fifo_pkg.sv
// Shared pipeline definitions for the valid/stall handshake and FIFO sizing.
package stall_fifo_pkg;

  // Handshake polarity: valid and stall are both active-high.
  localparam logic HS_VALID_ACTIVE = 1'b1;
  localparam logic HS_STALL_ACTIVE = 1'b1;

  // Pointer width for a DEPTH-entry buffer; at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stall_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module stall_fifo_mem
  import stall_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: combinational lookup at the read pointer.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/stall_fifo.sv
// Consumer end of a valid/stall pipeline link: buffers upstream data in a
// DEPTH-entry FIFO, stalls upstream when full, and re-presents data
// downstream with the same valid/stall convention.
module stall_fifo
  import stall_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       input_valid,
  output logic                       stall_out,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       stall_in,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;

  stall_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Handshake decode: stall_out comes from registered occupancy only, while
  // valid_out is suppressed combinationally by a downstream stall.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    nonempty  = (count_q != '0);
    stall_out = full;
    push      = input_valid && !full;
    valid_out = reset_n && !stall_in && nonempty;
    pop       = valid_out;
    // When empty, keep showing the last popped word rather than stale memory.
    data_out  = nonempty ? mem_rdata : last_q;
    count     = count_q;
  end

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_rdata;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; asynchronous reset discards all entries at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Occupancy sanity checks, evaluated only outside reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_q <= CW'(DEPTH))
        else $error("stall_fifo: count %0d exceeds depth %0d", count_q, DEPTH);
      assert (!(pop && (count_q == '0)))
        else $error("stall_fifo: pop while empty");
    end
  end

endmodule
